// File: rtl/led_mode_detector_pkg.sv
// Shared light-mode definitions used by both the LED driver and the detector,
// plus the per-window classification rule.
package led_mode_detector_pkg;

  // 2-bit light-mode encoding shared with the driver side
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_DIM   = 2'b11
  } light_mode_e;

  // Result of classifying one window; known=0 means UNKNOWN
  typedef struct packed {
    logic        known;
    light_mode_e mode;
  } win_class_t;

  // Confirm counter width, enough for CONFIRM up to 4
  localparam int unsigned CONF_W = 3;

  // Map a window's high-sample count and transition count to a class
  function automatic win_class_t classify(input int unsigned h,
                                          input int unsigned t,
                                          input int unsigned win);
    win_class_t c;
    c.known = 1'b1;
    c.mode  = MODE_OFF;
    if (h == 0 && t == 0) begin
      c.mode = MODE_OFF;
    end else if (h == win && t == 0) begin
      c.mode = MODE_ON;
    end else if (h == win / 2 && t == 2) begin
      c.mode = MODE_BLINK;
    end else if (h == (3 * win) / 4 && t == win / 2) begin
      c.mode = MODE_DIM;
    end else begin
      c.known = 1'b0;
      c.mode  = MODE_OFF;
    end
    return c;
  endfunction

endpackage

// File: rtl/led_mode_detector_window_stats.sv
// led_window_stats: free-running window counter with per-window high-sample
// (H) and transition (T) accumulation. The final H/T of a window are offered
// combinationally on the window's last sample so the caller can register them.
module led_window_stats
  import led_mode_detector_pkg::*;
#(
  parameter int unsigned WIN = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic                     smp_i,
  output logic                     win_last_c_o,
  output logic [$clog2(WIN):0]     h_c_o,
  output logic [$clog2(WIN):0]     t_c_o
);

  localparam int unsigned CNT_W = $clog2(WIN);
  localparam int unsigned ACC_W = CNT_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] h_q, h_d, t_q, t_d;
  logic             prev_q, prev_d;
  logic [ACC_W-1:0] h_sum, t_sum;
  logic             win_last;

  // Next-state: count the window, accumulate H/T, clear on the last sample
  always_comb begin
    cnt_d    = cnt_q;
    h_d      = h_q;
    t_d      = t_q;
    prev_d   = prev_q;
    h_sum    = h_q + ACC_W'(smp_i);
    t_sum    = t_q + ACC_W'(smp_i ^ prev_q);
    win_last = en_i && (cnt_q == CNT_W'(WIN - 1));
    if (en_i) begin
      cnt_d  = cnt_q + CNT_W'(1);
      prev_d = smp_i;
      h_d    = win_last ? '0 : h_sum;
      t_d    = win_last ? '0 : t_sum;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      h_q    <= '0;
      t_q    <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      h_q    <= h_d;
      t_q    <= t_d;
      prev_q <= prev_d;
    end
  end

  assign win_last_c_o = win_last;
  assign h_c_o        = h_sum;
  assign t_c_o        = t_sum;

endmodule

// File: rtl/led_mode_detector.sv
// led_mode_detector: classifies the LED drive waveform per window
// (OFF/ON/BLINK/DIM) and reports a mode once it is confirmed over CONFIRM
// consecutive agreeing windows. The first window after reset is a warm-up.
// Optional macro LED_MODE_DETECTOR_SYNC_EN adds a 2-flop input synchronizer;
// window counting is held off until that pipeline is primed, so every output
// event moves exactly 2 cycles later.
module led_mode_detector
  import led_mode_detector_pkg::*;
#(
  parameter int unsigned WIN     = 16,
  parameter int unsigned CONFIRM = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       mode_chg,
  output logic       win_done,
  output logic       bad
);

  localparam int unsigned ACC_W = $clog2(WIN) + 1;

  logic             smp;
  logic             stats_en;
  logic             win_last_c;
  logic [ACC_W-1:0] h_c, t_c;
  win_class_t       cls;

`ifdef LED_MODE_DETECTOR_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] prime_q;

  // Input synchronizer plus a matching prime chain gating window counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], led};
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  assign smp      = sync_q[1];
  assign stats_en = prime_q[1];
`else
  assign smp      = led;
  assign stats_en = 1'b1;
`endif

  led_window_stats #(
    .WIN (WIN)
  ) u_stats (
    .clk          (clk),
    .reset        (reset),
    .en_i         (stats_en),
    .smp_i        (smp),
    .win_last_c_o (win_last_c),
    .h_c_o        (h_c),
    .t_c_o        (t_c)
  );

  assign cls = classify(32'(h_c), 32'(t_c), WIN);

  logic              warm_q, warm_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  light_mode_e       prev_mode_q, prev_mode_d;
  light_mode_e       mode_q, mode_d;
  logic              valid_q, valid_d;
  logic              chg_q, chg_d;
  logic              done_q, done_d;
  logic              bad_q, bad_d;

  // Next-state: warm-up discard, confirm counting and mode update per window
  always_comb begin
    warm_d      = warm_q;
    conf_d      = conf_q;
    prev_mode_d = prev_mode_q;
    mode_d      = mode_q;
    valid_d     = valid_q;
    chg_d       = 1'b0;
    done_d      = 1'b0;
    bad_d       = 1'b0;
    if (win_last_c) begin
      if (warm_q) begin
        warm_d = 1'b0;
      end else begin
        done_d = 1'b1;
        if (!cls.known) begin
          bad_d  = 1'b1;
          conf_d = '0;
        end else begin
          if (conf_q != '0 && cls.mode == prev_mode_q) begin
            conf_d = (conf_q >= CONF_W'(CONFIRM)) ? CONF_W'(CONFIRM)
                                                  : conf_q + CONF_W'(1);
          end else begin
            conf_d = CONF_W'(1);
          end
          prev_mode_d = cls.mode;
          if (conf_d == CONF_W'(CONFIRM) && (cls.mode != mode_q || !valid_q)) begin
            mode_d  = cls.mode;
            valid_d = 1'b1;
            chg_d   = 1'b1;
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q      <= 1'b1;
      conf_q      <= '0;
      prev_mode_q <= MODE_OFF;
      mode_q      <= MODE_OFF;
      valid_q     <= 1'b0;
      chg_q       <= 1'b0;
      done_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      warm_q      <= warm_d;
      conf_q      <= conf_d;
      prev_mode_q <= prev_mode_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      chg_q       <= chg_d;
      done_q      <= done_d;
      bad_q       <= bad_d;
    end
  end

  assign mode       = mode_q;
  assign mode_valid = valid_q;
  assign mode_chg   = chg_q;
  assign win_done   = done_q;
  assign bad        = bad_q;

endmodule

// File: tb/tb_led_mode_detector.sv
// Directed bench for led_mode_detector (WIN=16, CONFIRM=2). Outputs are
// compared as the packed word {mode, mode_valid, mode_chg, win_done, bad}.
// Event indices kk count posedges after reset release minus the sync latency.
`timescale 1ns/1ps
module tb_led_mode_detector;

`ifdef LED_MODE_DETECTOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       led;
  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_chg;
  logic       win_done;
  logic       bad;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_mode_detector #(
    .WIN     (16),
    .CONFIRM (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .led        (led),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_chg   (mode_chg),
    .win_done   (win_done),
    .bad        (bad)
  );

  // Hold reset over a few edges, release 2ns after a rising edge
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    led   = 1'b0;
    repeat (cycles) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Reset values, quiet warm-up, and asynchronous assertion
  task automatic test_reset();
    logic [5:0] got;
    do_reset(3);
    got = {mode, mode_valid, mode_chg, win_done, bad};
    n_vec++;
    if (got !== 6'b0) begin
      n_err++;
      $display("FAIL reset_values got=%b exp=%b", got, 6'b0);
    end
    for (int n = 0; n < 6; n++) begin
      led = 1'b1;
      @(posedge clk);
      #2;
      got = {mode, mode_valid, mode_chg, win_done, bad};
      n_vec++;
      if (got !== 6'b0) begin
        n_err++;
        $display("FAIL reset_warmup n=%0d got=%b exp=%b", n, got, 6'b0);
      end
    end
    reset = 1'b1;
    #1;
    got = {mode, mode_valid, mode_chg, win_done, bad};
    n_vec++;
    if (got !== 6'b0) begin
      n_err++;
      $display("FAIL reset_async got=%b exp=%b", got, 6'b0);
    end
  endtask

  // led held high: ON confirmed at the end of the third window
  task automatic test_on_seq(input string tag, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      int         kk;
      logic [5:0] exp;
      logic [5:0] got;
      led = 1'b1;
      @(posedge clk);
      #2;
      kk  = n - LAT;
      exp = 6'b0;
      if (kk >= 47) exp[5:3] = 3'b011;
      if (kk == 47) exp[2] = 1'b1;
      if (kk >= 31 && (kk % 16) == 15) exp[1] = 1'b1;
      got = {mode, mode_valid, mode_chg, win_done, bad};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s n=%0d got=%b exp=%b", tag, n, got, exp);
      end
    end
  endtask

  task automatic test_on();
    do_reset(3);
    test_on_seq("on", 64 + LAT);
  endtask

  // Square wave of period 16 at phase 3: H=8, T=2 -> BLINK
  task automatic test_blink();
    do_reset(3);
    for (int n = 0; n < 64 + LAT; n++) begin
      int         kk;
      logic [5:0] exp;
      logic [5:0] got;
      led = (((n + 3) / 8) % 2) == 1;
      @(posedge clk);
      #2;
      kk  = n - LAT;
      exp = 6'b0;
      if (kk >= 47) exp[5:3] = 3'b101;
      if (kk == 47) exp[2] = 1'b1;
      if (kk >= 31 && (kk % 16) == 15) exp[1] = 1'b1;
      got = {mode, mode_valid, mode_chg, win_done, bad};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL blink n=%0d got=%b exp=%b", n, got, exp);
      end
    end
  endtask

  // 1,1,1,0 -> DIM with a single mode_chg, then fast toggle -> bad, mode held
  task automatic test_dim_then_bad();
    do_reset(3);
    for (int n = 0; n < 128 + LAT; n++) begin
      int         kk;
      logic [5:0] exp;
      logic [5:0] got;
      if (n < 80) led = (n % 4) != 3;
      else        led = ((n / 2) % 2) == 1;
      @(posedge clk);
      #2;
      kk  = n - LAT;
      exp = 6'b0;
      if (kk >= 47) exp[5:3] = 3'b111;
      if (kk == 47) exp[2] = 1'b1;
      if (kk >= 31 && (kk % 16) == 15) exp[1] = 1'b1;
      if (kk == 95 || kk == 111 || kk == 127) exp[0] = 1'b1;
      got = {mode, mode_valid, mode_chg, win_done, bad};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL dim_bad n=%0d got=%b exp=%b", n, got, exp);
      end
    end
  endtask

  // ON confirmed, reset mid-window, then warm-up and a fresh confirmation
  task automatic test_reset_mid();
    logic [5:0] got;
    do_reset(3);
    test_on_seq("mid_pre", 56 + LAT);
    reset = 1'b1;
    #1;
    got = {mode, mode_valid, mode_chg, win_done, bad};
    n_vec++;
    if (got !== 6'b0) begin
      n_err++;
      $display("FAIL mid_reset_async got=%b exp=%b", got, 6'b0);
    end
    do_reset(3);
    test_on_seq("mid_post", 64 + LAT);
  endtask

  initial begin
    reset = 1'b1;
    led   = 1'b0;
    test_reset();
    test_on();
    test_blink();
    test_dim_then_bad();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_mode_detector.md
LED_MODE_DETECTOR -- requirements
Module: led_mode_detector

Interface
REQ-001 SHALL have parameter WIN, default 16, meaning the observation window length in clk cycles (a power of 2, 8..256).
REQ-002 SHALL have parameter CONFIRM, default 2, meaning the number of consecutive agreeing windows needed to change the reported mode (1..4).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port led  input  1  the observed light-drive waveform.
REQ-006 SHALL have port mode  output  2  the confirmed mode: 00 OFF, 01 ON, 10 BLINK, 11 DIM.
REQ-007 SHALL have port mode_valid  output  1  set once the first mode has been confirmed.
REQ-008 SHALL have port mode_chg  output  1  one-cycle pulse when mode changes value or first becomes valid.
REQ-009 SHALL have port win_done  output  1  one-cycle pulse on the cycle after each window closes.
REQ-010 SHALL have port bad  output  1  one-cycle pulse, coincident with win_done, when that window is unclassifiable.

Function
REQ-011 SHALL sample the led input (after the optional synchronizer) every cycle into a window counter running 0..WIN-1, wrapping to 0.
REQ-012 SHALL count, per window, the high samples H (0..WIN) and the transitions T, where T counts samples that differ from the previous cycle's sample, including across the window boundary.
REQ-013 SHALL classify each closed window as follows:
- H==0 and T==0: OFF.
- H==WIN and T==0: ON.
- H==WIN/2 and T==2: BLINK.
- H==3*WIN/4 and T==WIN/2: DIM.
- Anything else: UNKNOWN.
REQ-014 SHALL register the classification, win_done and bad on the cycle after the window's last sample, which is 1 cycle of latency from window close.
REQ-015 SHALL discard the first window after reset (warm-up): no classification, no win_done.
REQ-016 SHALL keep a confirm counter of consecutive windows with the same valid class; an UNKNOWN window or a class differing from the previous window resets the count to 1 (0 for UNKNOWN).
REQ-017 SHALL, when the confirm count reaches CONFIRM and the class differs from mode or mode_valid is 0, update mode and set mode_valid on the same cycle as win_done, and pulse mode_chg.
REQ-018 SHALL hold mode unchanged on UNKNOWN windows; bad pulses and mode_valid stays at its current value.
REQ-019 SHALL not pulse mode_chg when a confirmed class equals the current mode.
REQ-020 SHALL saturate the confirm counter at CONFIRM (no wrap).

Reset
REQ-021 SHALL, on assertion of reset, immediately force the following values:
- mode=00, mode_valid=0, mode_chg=0, win_done=0, bad=0.
- Window counter, H, T, the previous-sample register and the confirm count all to 0.
- The warm-up flag set.
REQ-022 SHALL abandon a partially observed window on reset mid-window, and restart with a warm-up window after deassertion.

Configuration
REQ-023 SHALL, with LED_MODE_DETECTOR_SYNC_EN defined, pass led through a 2-flop synchronizer reset to 0, adding 2 cycles to every latency.
REQ-024 SHALL, without LED_MODE_DETECTOR_SYNC_EN, sample led directly and require it to be synchronous to clk.

Structure
REQ-025 SHALL take the mode encodings (OFF/ON/BLINK/DIM, 2 bits) from the shared light-mode definitions header, which is used by both driver and detector.
REQ-026 SHALL place the window counter and the H/T accumulation in one sub-module, led_window_stats; classification and confirmation stay in the top module.

Verification (WIN=16, CONFIRM=2, sync disabled)
REQ-027 SHALL verify: led held 1 from reset release -> warm-up window, then mode=01, mode_valid=1 and mode_chg pulse at the end of window 3; no bad.
REQ-028 SHALL verify: led toggling every 8 cycles, arbitrary phase -> H=8, T=2 each window; mode=10 after 2 classified windows.
REQ-029 SHALL verify: led pattern 1,1,1,0 repeating -> H=12, T=8; mode=11 after 2 classified windows; no further mode_chg while the pattern continues.
REQ-030 SHALL verify: after DIM is confirmed, switch to led toggling every 2 cycles (H=8, T=8) -> bad pulses every window; mode stays 11.
REQ-031 SHALL verify: ON confirmed, then reset asserted for 3 cycles mid-window -> outputs 0 immediately; after release, warm-up window then a fresh confirmation.
REQ-032 SHALL verify: with LED_MODE_DETECTOR_SYNC_EN defined, the REQ-027 stimulus gives the same results with every output event delayed by exactly 2 cycles.
